// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter signals of the shared UART byte scheduler.
// Handshake: a requester holds req_valid, req_data and req_last stable until it sees its
// req_ready bit high for one cycle; the byte is transferred at the clock edge ending that cycle.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_tx_data;
    logic                 uart_tx_start;
    logic                 uart_tx_done;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic [NUM_REQ-1:0]   err_timeout;
    logic                 err_clr;
    logic [1:0]           state_dbg;

    modport master (
        output req_valid, req_data, req_last, uart_tx_done, err_clr,
        input  req_ready, uart_tx_data, uart_tx_start, grant_id, busy, err_timeout, state_dbg
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_tx_done, err_clr,
        output req_ready, uart_tx_data, uart_tx_start, grant_id, busy, err_timeout, state_dbg
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among NUM_REQ requesters,
// with packet lock, inter-frame gap and a per-requester sticky timeout flag.
module uart_tx_sched #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input logic            clk,
    input logic            rst_n,
    uart_tx_sched_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [23:0]      TO_LAST  = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic               lock;
    logic [23:0]        to_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic [ID_W-1:0]    grant;
    logic               busy_q;
    logic [NUM_REQ-1:0] err_q;

    logic               found;
    logic [ID_W-1:0]    win;
    logic [NUM_REQ-1:0] win_mask;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // Search wraps at NUM_REQ explicitly so a non-power-of-2 count never selects a missing requester.
    always_comb begin
        logic [ID_W:0] sum;
        found = 1'b0;
        win   = '0;
        sum   = '0;
        if (lock) begin
            found = bus.req_valid[grant];
            win   = grant;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
                if (sum >= (ID_W+1)'(NUM_REQ)) begin
                    sum = sum - (ID_W+1)'(NUM_REQ);
                end
                if (!found && bus.req_valid[sum[ID_W-1:0]]) begin
                    found = 1'b1;
                    win   = sum[ID_W-1:0];
                end
            end
        end
        win_mask = found ? (NUM_REQ'(1) << win) : '0;
    end

    // Ready is offered only from IDLE so the accept lands in the same cycle as the arbitration.
    assign bus.req_ready     = (rst_n && state == IDLE) ? win_mask : '0;
    assign bus.uart_tx_data  = tx_data;
    assign bus.uart_tx_start = tx_start;
    assign bus.grant_id      = grant;
    assign bus.busy          = busy_q;
    assign bus.err_timeout   = err_q;
    assign bus.state_dbg     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock     <= 1'b0;
            to_cnt   <= '0;
            gap_cnt  <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            grant    <= '0;
            busy_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        tx_data  <= bus.req_data[{win, 3'b000} +: 8];
                        grant    <= win;
                        tx_start <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= START;
                        if (bus.req_last[win]) begin
                            lock   <= 1'b0;
                            rr_ptr <= wrap_inc(win);
                        end else begin
                            lock <= 1'b1;
                        end
                    end
                end
                START: begin
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (bus.uart_tx_done) begin
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                        busy_q  <= (GAP_CYCLES != 0);
                    end else if (to_cnt == TO_LAST) begin
                        err_q[grant] <= 1'b1;
                        lock         <= 1'b0;
                        rr_ptr       <= wrap_inc(grant);
                        gap_cnt      <= '0;
                        state        <= (GAP_CYCLES == 0) ? IDLE : GAP;
                        busy_q       <= (GAP_CYCLES != 0);
                    end else begin
                        to_cnt <= to_cnt + 24'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A clear wins over a timeout flagged in the same cycle.
            if (bus.err_clr) begin
                err_q <= '0;
            end
        end
    end
endmodule
